ram_arbiter: RTL and testbench
==============================

// Module: ram_arbiter
// PURPOSE
//  Shares the single-port 4K x 8 CHIP-8 RAM between three requesters: the ROM/font loader, the CPU and the blitter.
//  Each requester issues single-cycle transactions with a req/gnt handshake, and read data returns one cycle after the grant.
//  A starvation counter keeps the CPU from locking out sprite fetches indefinitely.
//  The block sits between cpu/blitter/loader and the RAM primitive, replacing their direct ram_* connections.
// PARAMETERS
//  ADDR_W        12  RAM address width
//  DATA_W        8   RAM data width
//  STARVE_LIMIT  4   consecutive denied blit cycles before the blitter outranks the CPU (1..15)
// PORTS
//  clk          in   1       system clock
//  rst          in   1       synchronous reset, active-high
//  load_req     in   1       loader write request
//  load_addr    in   ADDR_W  loader write address
//  load_wdata   in   DATA_W  loader write data
//  load_gnt     out  1       loader write accepted this cycle
//  cpu_req      in   1       CPU request
//  cpu_wr       in   1       1 = write, 0 = read
//  cpu_addr     in   ADDR_W  CPU address
//  cpu_wdata    in   DATA_W  CPU write data
//  cpu_gnt      out  1       CPU transaction accepted this cycle
//  cpu_rvalid   out  1       cpu_rdata valid (one-cycle pulse)
//  cpu_rdata    out  DATA_W  CPU read data
//  blit_req     in   1       blitter read request (read-only)
//  blit_addr    in   ADDR_W  blitter read address
//  blit_gnt     out  1       blitter read accepted this cycle
//  blit_rvalid  out  1       blit_rdata valid (one-cycle pulse)
//  blit_rdata   out  DATA_W  blitter read data
//  ram_en       out  1       RAM enable
//  ram_wr       out  1       RAM write strobe
//  ram_addr     out  ADDR_W  RAM address
//  ram_in       out  DATA_W  RAM write data
//  ram_out      in   DATA_W  RAM read data (synchronous, 1-cycle latency)
// BEHAVIOUR
//  - Reset: all *_gnt=0, *_rvalid=0, *_rdata=0, ram_en=ram_wr=0, ram_addr=ram_in=0, starve_cnt=0, rd_owner=NONE.
//    While rst=1, grants are forced to 0.
//  - Arbitration is combinational in cycle N, with at most one grant per cycle. Priority order:
//    1. load_req
//    2. blit_req, when starve_cnt==STARVE_LIMIT
//    3. cpu_req
//    4. blit_req
//  - The winner's address, data and write strobe are muxed onto ram_* in the same cycle N, with ram_en=1.
//    With no winner: ram_en=0, ram_wr=0, and ram_addr/ram_in hold their previous values.
//  - Requester contract: req, addr, wr and wdata stay stable until gnt. The cycle after gnt, req may re-assert for a back-to-back transaction.
//  - Read return: rd_owner register in {NONE, CPU, BLIT} records the granted reader at the end of cycle N.
//    In N+1 the owner's *_rvalid=1 and *_rdata=ram_out; *_rdata holds that value until the next read return.
//    Writes never produce rvalid.
//  - starve_cnt (4 bit):
//    - +1 each cycle blit_req=1 && blit_gnt=0, saturating at STARVE_LIMIT.
//    - Cleared on blit_gnt or blit_req=0.
//    - A loader grant neither clears starve_cnt nor counts as a blitter win.
//  - Simultaneous load_req + anything: the loader always wins, and the others retry next cycle with unchanged requests.
//  - Reset mid-read: a read granted in cycle N with rst=1 in N+1 produces no rvalid in N+1; rd_owner=NONE.
//  - Address arithmetic: none. Addresses pass through unmodified and are never incremented or wrapped here.
//  - Throughput: one transaction per cycle sustained. Read latency is 1 cycle from grant.
// TESTING
//  - CPU read: RAM[0x200]=0xA2, cpu_req=1, cpu_wr=0, cpu_addr=0x200 -> cpu_gnt=1, ram_en=1, ram_wr=0, ram_addr=0x200 same cycle; next cycle cpu_rvalid=1, cpu_rdata=0xA2.
//  - CPU write then read: write 0x55 to 0x400 (ram_wr=1, ram_in=0x55), then read 0x400 -> cpu_rdata=0x55 one cycle after the read grant.
//  - Starvation: cpu_req and blit_req held high continuously, STARVE_LIMIT=4 -> cpu_gnt in cycles 0-3, blit_gnt in cycle 4, cpu_gnt in cycles 5-8, blit_gnt in cycle 9.
//  - Loader priority: load_req, cpu_req and blit_req all high -> only load_gnt=1, ram_wr=1, ram_addr=load_addr; cpu_gnt=blit_gnt=0.
//  - Blitter burst: blit_req held high with addr 0x300..0x30F advanced on each gnt, RAM preloaded with addr[7:0] -> 16 consecutive blit_rvalid pulses with data 0x00..0x0F in order.
//  - Reset mid-read: grant a blit read at 0x300 and assert rst the next cycle -> blit_rvalid=0, all grants 0, starve_cnt=0; normal operation after rst deasserts.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if
//   Bundles every signal between the CHIP-8 RAM arbiter and its neighbours:
//   the three requesters (loader, CPU, blitter), the single-port RAM, and a
//   small debug view of the arbiter's internal state.
//
//   Handshake (same for all three requesters): a requester raises *_req with
//   its address/data/write strobe and keeps all of them stable until it sees
//   *_gnt=1 in the same cycle. A granted request is complete at that clock
//   edge; req may stay high (or re-assert) the very next cycle for a
//   back-to-back transaction. Reads return *_rvalid=1 with *_rdata exactly one
//   cycle after the grant.
//
//   Modports:
//     slave  - the arbiter side (drives grants, read returns and ram_* pins)
//     master - the environment side (requesters plus the RAM primitive)
interface ram_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  // Loader (write-only)
  logic              load_req;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_wdata;
  logic              load_gnt;
  // CPU (read/write)
  logic              cpu_req;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  // Blitter (read-only)
  logic              blit_req;
  logic [ADDR_W-1:0] blit_addr;
  logic              blit_gnt;
  logic              blit_rvalid;
  logic [DATA_W-1:0] blit_rdata;
  // RAM primitive
  logic              ram_en;
  logic              ram_wr;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_in;
  logic [DATA_W-1:0] ram_out;
  // Debug view of arbiter state
  logic [3:0]        dbg_starve_cnt;
  logic [1:0]        dbg_rd_owner;

  modport slave (
    input  load_req, load_addr, load_wdata,
    input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    input  blit_req, blit_addr,
    input  ram_out,
    output load_gnt,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output blit_gnt, blit_rvalid, blit_rdata,
    output ram_en, ram_wr, ram_addr, ram_in,
    output dbg_starve_cnt, dbg_rd_owner
  );

  modport master (
    output load_req, load_addr, load_wdata,
    output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    output blit_req, blit_addr,
    output ram_out,
    input  load_gnt,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  blit_gnt, blit_rvalid, blit_rdata,
    input  ram_en, ram_wr, ram_addr, ram_in,
    input  dbg_starve_cnt, dbg_rd_owner
  );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares the single-port 4K x 8 CHIP-8 RAM between the ROM/font loader, the
//   CPU and the blitter. At most one single-cycle transaction is granted per
//   clock; priority is loader, then a starved blitter, then CPU, then blitter.
//   Read data comes back one cycle after the grant on the owner's rdata port.
//
//   Ports:
//     clk   - system clock
//     rst   - synchronous reset, active-high (also forces all grants low)
//     bus   - ram_arbiter_if.slave: requester handshakes, ram_* pins, debug
//             (dbg_starve_cnt = starvation counter, dbg_rd_owner = 0 none,
//             1 CPU, 2 blitter)
module ram_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_BLIT = 2'd2
  } owner_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  owner_e            rd_owner_q, rd_owner_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] in_q, in_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] blit_rdata_q, blit_rdata_d;

  logic load_gnt, cpu_gnt, blit_gnt;
  logic ram_wr;
  logic cpu_rvalid, blit_rvalid;

  // Arbitration and RAM-side mux. addr_d/in_d double as the driven ram_addr
  // and ram_in values: with no winner they simply keep the registered copy,
  // which gives the "hold previous value" behaviour for free.
  always_comb begin
    load_gnt = 1'b0;
    cpu_gnt  = 1'b0;
    blit_gnt = 1'b0;
    ram_wr   = 1'b0;
    addr_d   = addr_q;
    in_d     = in_q;
    if (rst) begin
      addr_d = '0;
      in_d   = '0;
    end else if (bus.load_req) begin
      load_gnt = 1'b1;
      ram_wr   = 1'b1;
      addr_d   = bus.load_addr;
      in_d     = bus.load_wdata;
    end else if (bus.blit_req && (starve_cnt_q == LIMIT)) begin
      blit_gnt = 1'b1;
      addr_d   = bus.blit_addr;
    end else if (bus.cpu_req) begin
      cpu_gnt = 1'b1;
      ram_wr  = bus.cpu_wr;
      addr_d  = bus.cpu_addr;
      in_d    = bus.cpu_wdata;
    end else if (bus.blit_req) begin
      blit_gnt = 1'b1;
      addr_d   = bus.blit_addr;
    end
  end

  // Read-return tracking and starvation counter.
  always_comb begin
    rd_owner_d   = OWN_NONE;
    starve_cnt_d = '0;
    cpu_rvalid   = 1'b0;
    blit_rvalid  = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    blit_rdata_d = blit_rdata_q;
    if (rst) begin
      cpu_rdata_d  = '0;
      blit_rdata_d = '0;
    end else begin
      if (cpu_gnt && !bus.cpu_wr) begin
        rd_owner_d = OWN_CPU;
      end else if (blit_gnt) begin
        rd_owner_d = OWN_BLIT;
      end
      // A reset in the return cycle swallows the pending read entirely.
      cpu_rvalid  = (rd_owner_q == OWN_CPU);
      blit_rvalid = (rd_owner_q == OWN_BLIT);
      if (cpu_rvalid) begin
        cpu_rdata_d = bus.ram_out;
      end
      if (blit_rvalid) begin
        blit_rdata_d = bus.ram_out;
      end
      // Denied cycles count, including ones lost to the loader; only a
      // blitter grant or a dropped request clears the count.
      if (bus.blit_req && !blit_gnt) begin
        starve_cnt_d = (starve_cnt_q == LIMIT) ? starve_cnt_q : starve_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_owner_q   <= OWN_NONE;
      starve_cnt_q <= '0;
      addr_q       <= '0;
      in_q         <= '0;
      cpu_rdata_q  <= '0;
      blit_rdata_q <= '0;
    end else begin
      rd_owner_q   <= rd_owner_d;
      starve_cnt_q <= starve_cnt_d;
      addr_q       <= addr_d;
      in_q         <= in_d;
      cpu_rdata_q  <= cpu_rdata_d;
      blit_rdata_q <= blit_rdata_d;
    end
  end

  assign bus.load_gnt       = load_gnt;
  assign bus.cpu_gnt        = cpu_gnt;
  assign bus.blit_gnt       = blit_gnt;
  assign bus.cpu_rvalid     = cpu_rvalid;
  assign bus.blit_rvalid    = blit_rvalid;
  assign bus.cpu_rdata      = cpu_rdata_d;
  assign bus.blit_rdata     = blit_rdata_d;
  assign bus.ram_en         = load_gnt | cpu_gnt | blit_gnt;
  assign bus.ram_wr         = ram_wr;
  assign bus.ram_addr       = addr_d;
  assign bus.ram_in         = in_d;
  assign bus.dbg_starve_cnt = starve_cnt_q;
  assign bus.dbg_rd_owner   = rd_owner_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
//   Bench for ram_arbiter: a synchronous RAM model, a rule-level reference
//   model evaluated every cycle, a priority table, directed multi-cycle
//   sequences and a randomized phase with contract-abiding requesters.
module tb_ram_arbiter;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;
  localparam int LIMIT  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- RAM primitive model ----------------
  logic [7:0] sh_mem [4096];   // expected RAM contents (model side)
  logic [7:0] mem    [4096];   // the RAM itself
  logic       mem_init = 1'b0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 4096; i++) mem[i] <= sh_mem[i];
      mem_init <= 1'b1;
    end else if (bus.ram_en) begin
      if (bus.ram_wr) mem[bus.ram_addr] <= bus.ram_in;
      else            bus.ram_out <= mem[bus.ram_addr];
    end
  end

  // ---------------- scoreboard / model state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q [$];
  int         m_starve = 0;
  int         m_owner  = 0;      // 0 none, 1 CPU, 2 blitter
  logic [11:0] m_addr = '0;
  logic [7:0]  m_in = '0, m_crd = '0, m_brd = '0;
  logic [2:0]  lg;               // model grants {load, cpu, blit} of last cycle

  // sampled DUT outputs of the last cycle
  logic [2:0]  s_gnt;
  logic        s_en, s_wr, s_cvld, s_bvld;
  logic [11:0] s_addr;
  logic [7:0]  s_in, s_crd, s_brd;
  logic [3:0]  s_starve;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    bus.load_req = 1'b0;
    bus.cpu_req  = 1'b0;
    bus.blit_req = 1'b0;
  endtask

  // One clock cycle: called just after a negedge with inputs driven. Samples
  // the DUT mid-cycle, compares against the reference rules, advances the
  // model and returns at the next negedge.
  task automatic cycle();
    logic gl, gc, gb, e_en, e_wr, e_cv, e_bv;
    logic [11:0] e_addr;
    logic [7:0]  e_in, e_crd, e_brd, rd;
    #1;
    s_gnt    = {bus.load_gnt, bus.cpu_gnt, bus.blit_gnt};
    s_en     = bus.ram_en;
    s_wr     = bus.ram_wr;
    s_addr   = bus.ram_addr;
    s_in     = bus.ram_in;
    s_cvld   = bus.cpu_rvalid;
    s_crd    = bus.cpu_rdata;
    s_bvld   = bus.blit_rvalid;
    s_brd    = bus.blit_rdata;
    s_starve = bus.dbg_starve_cnt;

    gl = !rst && bus.load_req;
    gb = !rst && !gl && bus.blit_req && ((m_starve == LIMIT) || !bus.cpu_req);
    gc = !rst && !gl && !gb && bus.cpu_req;
    e_en = gl || gc || gb;
    e_wr = gl || (gc && bus.cpu_wr);
    e_addr = rst ? 12'h0 : gl ? bus.load_addr : gc ? bus.cpu_addr : gb ? bus.blit_addr : m_addr;
    e_in   = rst ? 8'h0 : gl ? bus.load_wdata : gc ? bus.cpu_wdata : m_in;
    rd = 8'h0;
    if (m_owner != 0 && exp_q.size() > 0) rd = exp_q.pop_front();
    e_cv  = !rst && (m_owner == 1);
    e_bv  = !rst && (m_owner == 2);
    e_crd = rst ? 8'h0 : e_cv ? rd : m_crd;
    e_brd = rst ? 8'h0 : e_bv ? rd : m_brd;

    chk("grants", 32'(s_gnt), 32'({gl, gc, gb}));
    chk("ram_en", 32'(s_en), 32'(e_en));
    chk("ram_wr", 32'(s_wr), 32'(e_wr));
    chk("ram_addr", 32'(s_addr), 32'(e_addr));
    chk("ram_in", 32'(s_in), 32'(e_in));
    chk("cpu_rvalid", 32'(s_cvld), 32'(e_cv));
    chk("cpu_rdata", 32'(s_crd), 32'(e_crd));
    chk("blit_rvalid", 32'(s_bvld), 32'(e_bv));
    chk("blit_rdata", 32'(s_brd), 32'(e_brd));
    chk("starve_cnt", 32'(s_starve), 32'(m_starve));

    m_crd  = e_crd;
    m_brd  = e_brd;
    m_addr = e_addr;
    m_in   = e_in;
    m_owner = (gc && !bus.cpu_wr) ? 1 : gb ? 2 : 0;
    if (m_owner != 0) exp_q.push_back(sh_mem[e_addr]);
    if (e_wr) sh_mem[e_addr] = e_in;
    if (rst || !bus.blit_req || gb) m_starve = 0;
    else if (m_starve < LIMIT)      m_starve = m_starve + 1;
    lg = {gl, gc, gb};
    @(negedge clk);
  endtask

  // ---------------- priority table ----------------
  typedef struct {
    logic        l, c, cw, b;
    logic [2:0]  gnt;
    logic        wr;
    logic [11:0] addr;
  } vec_t;
  vec_t tbl [9];

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] got [16];
    int n_got, first_v, last_v, n_bg;
    logic l_pend, c_pend, b_pend;

    for (int i = 0; i < 4096; i++) sh_mem[i] = 8'($urandom);
    sh_mem[12'h200] = 8'hA2;
    for (int i = 0; i < 16; i++) sh_mem[12'h300 + i] = 8'(i);

    bus.load_addr = '0; bus.load_wdata = '0;
    bus.cpu_wr = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.blit_addr = '0;
    set_idle();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // reset state
    cycle();
    chk("reset_gnt", 32'(s_gnt), 32'h0);
    chk("reset_en", 32'(s_en), 32'h0);
    chk("reset_addr", 32'(s_addr), 32'h0);
    chk("reset_rdata", 32'({s_crd, s_brd}), 32'h0);
    rst = 1'b0;
    cycle();

    // CPU read of 0x200
    bus.cpu_req = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_addr = 12'h200;
    cycle();
    chk("cpurd_gnt", 32'(s_gnt), 32'b010);
    chk("cpurd_addr", 32'({s_en, s_wr, s_addr}), 32'({1'b1, 1'b0, 12'h200}));
    set_idle();
    cycle();
    chk("cpurd_rvalid", 32'(s_cvld), 32'h1);
    chk("cpurd_rdata", 32'(s_crd), 32'hA2);

    // CPU write 0x55 to 0x400 then read it back
    bus.cpu_req = 1'b1; bus.cpu_wr = 1'b1; bus.cpu_addr = 12'h400; bus.cpu_wdata = 8'h55;
    cycle();
    chk("cpuwr_strobe", 32'({s_wr, s_in}), 32'({1'b1, 8'h55}));
    bus.cpu_wr = 1'b0;
    cycle();
    set_idle();
    cycle();
    chk("cpuwr_readback", 32'({s_cvld, s_crd}), 32'({1'b1, 8'h55}));

    // priority table, each entry applied from an idle (unstarved) cycle
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 12'h000};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 1'b1, 12'h0A0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, 12'h210};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 1'b1, 12'h210};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0, 12'h310};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'b010, 1'b0, 12'h210};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b100, 1'b1, 12'h0A0};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'b100, 1'b1, 12'h0A0};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 3'b010, 1'b1, 12'h210};
    bus.load_addr = 12'h0A0; bus.cpu_addr = 12'h210; bus.blit_addr = 12'h310;
    for (int i = 0; i < 9; i++) begin
      set_idle();
      cycle();
      bus.load_req = tbl[i].l; bus.cpu_req = tbl[i].c; bus.cpu_wr = tbl[i].cw;
      bus.blit_req = tbl[i].b;
      bus.load_wdata = 8'($urandom); bus.cpu_wdata = 8'($urandom);
      cycle();
      chk("tbl_gnt", 32'(s_gnt), 32'(tbl[i].gnt));
      chk("tbl_wr", 32'(s_wr), 32'(tbl[i].wr));
      if (tbl[i].gnt != 3'b000) chk("tbl_addr", 32'(s_addr), 32'(tbl[i].addr));
      else                      chk("tbl_en", 32'(s_en), 32'h0);
    end

    // starvation: CPU and blitter both held high
    set_idle();
    cycle();
    bus.cpu_req = 1'b1; bus.cpu_wr = 1'b0; bus.blit_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("starve_pattern", 32'(s_gnt), (i == 4 || i == 9) ? 32'b001 : 32'b010);
    end

    // blitter burst 0x300..0x30F
    set_idle();
    cycle();
    cycle();
    bus.blit_req = 1'b1; bus.blit_addr = 12'h300;
    n_got = 0; n_bg = 0; first_v = -1; last_v = -1;
    for (int k = 0; k < 40 && n_got < 16; k++) begin
      cycle();
      if (s_bvld) begin
        if (first_v < 0) first_v = k;
        last_v = k;
        got[n_got] = s_brd;
        n_got++;
      end
      if (s_gnt[0]) begin
        n_bg++;
        if (n_bg == 16) bus.blit_req = 1'b0;
        else bus.blit_addr = bus.blit_addr + 12'd1;
      end
    end
    chk("burst_count", 32'(n_got), 32'd16);
    chk("burst_consecutive", 32'(last_v - first_v), 32'd15);
    for (int i = 0; i < n_got; i++) chk("burst_data", 32'(got[i]), 32'(i));

    // reset in the cycle after a blitter read grant
    set_idle();
    cycle();
    bus.blit_req = 1'b1; bus.blit_addr = 12'h300;
    cycle();
    chk("rstrd_gnt", 32'(s_gnt), 32'b001);
    set_idle();
    rst = 1'b1;
    cycle();
    chk("rstrd_rvalid", 32'(s_bvld), 32'h0);
    chk("rstrd_gnt0", 32'(s_gnt), 32'h0);
    rst = 1'b0;
    cycle();
    chk("rstrd_starve", 32'(s_starve), 32'h0);
    chk("rstrd_no_late_rvalid", 32'({s_cvld, s_bvld}), 32'h0);
    bus.cpu_req = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_addr = 12'h200;
    cycle();
    set_idle();
    cycle();
    chk("rstrd_recover", 32'({s_cvld, s_crd}), 32'({1'b1, 8'hA2}));

    // randomized traffic against the model
    l_pend = 1'b0; c_pend = 1'b0; b_pend = 1'b0;
    for (int n = 0; n < 2500; n++) begin
      bus.load_req = l_pend; bus.cpu_req = c_pend; bus.blit_req = b_pend;
      rst = ($urandom_range(0, 149) == 0);
      cycle();
      if (lg[2]) l_pend = 1'b0;
      if (lg[1]) c_pend = 1'b0;
      if (lg[0]) b_pend = 1'b0;
      if (!l_pend && $urandom_range(0, 19) == 0) begin
        l_pend = 1'b1;
        bus.load_addr = 12'($urandom_range(0, 63));
        bus.load_wdata = 8'($urandom);
      end
      if (!c_pend && $urandom_range(0, 2) != 0) begin
        c_pend = 1'b1;
        bus.cpu_wr = 1'($urandom_range(0, 1));
        bus.cpu_addr = 12'($urandom_range(0, 63));
        bus.cpu_wdata = 8'($urandom);
      end
      if (!b_pend && $urandom_range(0, 1) == 0) begin
        b_pend = 1'b1;
        bus.blit_addr = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'($urandom_range(0, 63));
      end
    end
    rst = 1'b0;
    set_idle();
    cycle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
